mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles; legal values 1..4.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports c_req, c_we  input  1 each  CPU access request and write enable.
REQ-005 SHALL have ports c_addr, c_wdata  input  8 each  CPU address and write data.
REQ-006 SHALL have ports c_gnt, c_done  output  1 each  CPU grant and one-cycle completion pulse.
REQ-007 SHALL have ports d_req, d_we  input  1 each  loader/DMA request and write enable.
REQ-008 SHALL have ports d_addr, d_wdata  input  8 each  loader address and write data.
REQ-009 SHALL have ports d_gnt, d_done  output  1 each  loader grant and one-cycle completion pulse.
REQ-010 SHALL have port rdata  output  8  read data returned to the current owner.
REQ-011 SHALL have ports mem_addr, mem_wdata  output  8 each  and mem_we  output  1  to the single-port memory.
REQ-012 SHALL have port mem_rdata  input  8  memory read data, valid MEM_LAT cycles after address is sampled.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; one access in flight at most.
REQ-014 IDLE: at a rising edge with any req high, SHALL select a winner, latch its addr/wdata/we and owner id, and enter ISSUE; with no req, SHALL remain in IDLE.
REQ-015 Winner selection: single requester wins; both high -> requester not served last (1-bit pointer `last`) wins.
REQ-016 Pointer `last` SHALL update to the owner on entry to DONE.
REQ-017 ISSUE (exactly one cycle): mem_addr = latched addr, mem_wdata = latched wdata, mem_we = latched we; next state WAIT.
REQ-018 WAIT SHALL last exactly MEM_LAT cycles via a down-counter loaded with MEM_LAT-1 on entry to WAIT; at the edge leaving the last WAIT cycle, rdata SHALL capture mem_rdata on reads and hold its prior value on writes.
REQ-019 DONE (exactly one cycle): owner's done = 1; next state IDLE.
REQ-020 Owner's gnt SHALL be 1 throughout ISSUE, WAIT and DONE; the other gnt 0; both 0 in IDLE.
REQ-021 mem_we SHALL be 1 only in ISSUE; mem_addr/mem_wdata SHALL hold latched values outside ISSUE.
REQ-022 Latency: req sampled at edge E0 -> done high in the cycle after edge E(1+MEM_LAT); one access per MEM_LAT+3 cycles.
REQ-023 Requester deasserting req or changing addr/wdata/we after the sampling edge SHALL NOT affect the access in flight; it completes normally.
REQ-024 A requester whose req is still high in IDLE after its DONE SHALL be treated as a new request; with both high it loses to the other (strict alternation).
REQ-025 Outputs SHALL be registered or decoded from state only (Moore); no combinational path from req inputs to gnt/mem outputs.

Reset
REQ-026 On reset low, immediately and independent of clk: state IDLE, c_gnt = d_gnt = 0, c_done = d_done = 0, mem_we = 0, mem_addr = mem_wdata = rdata = 8'h00, counter = 0, last = loader (CPU wins first tie).
REQ-027 Reset asserted mid-access SHALL abort the access with no done pulse; after release, pending reqs are arbitrated afresh from IDLE.

Verification
REQ-028 CPU read, MEM_LAT=1, mem holds 8'hA5 at 8'h10: c_req=1, c_addr=8'h10 sampled at E0 -> c_gnt high E0..E3, mem_we=0, c_done pulse after E2, rdata=8'hA5.
REQ-029 Loader write 8'h3C to 8'h20: -> mem_we=1 for exactly one cycle with mem_addr=8'h20, mem_wdata=8'h3C; d_done pulse; rdata unchanged.
REQ-030 c_req and d_req both held high from reset release -> grants alternate CPU, loader, CPU, loader; each done pulses once per access; never both gnt high.
REQ-031 MEM_LAT=3, CPU read: WAIT lasts 3 cycles; c_done after E4; rdata equals mem_rdata sampled at E4.
REQ-032 Reset asserted during WAIT -> all gnt/done/mem_we 0 immediately; no done pulse; next CPU request after release completes normally.
REQ-033 c_req dropped and c_addr changed during ISSUE -> access completes to the originally latched address with c_done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Two-requester (CPU / loader) round-robin arbiter for a
//               single-port memory with fixed read latency MEM_LAT.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       c_req,
    input  logic       c_we,
    input  logic [7:0] c_addr,
    input  logic [7:0] c_wdata,
    output logic       c_gnt,
    output logic       c_done,
    input  logic       d_req,
    input  logic       d_we,
    input  logic [7:0] d_addr,
    input  logic [7:0] d_wdata,
    output logic       d_gnt,
    output logic       d_done,
    output logic [7:0] rdata,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic       c_cpu      = 1'b0;
    localparam logic       c_ldr      = 1'b1;
    localparam logic [1:0] c_cnt_load = 2'(MEM_LAT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_winner;
    logic       w_any_req;
    logic       r_owner;
    logic       r_last;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [1:0] r_cnt;

    assign w_any_req = c_req | d_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_next_state = r_state;
        w_winner     = c_cpu;
        if (c_req && d_req) begin
            w_winner = ~r_last;
        end else if (d_req) begin
            w_winner = c_ldr;
        end
        case (r_state)
            ST_IDLE:  if (w_any_req) w_next_state = ST_ISSUE;
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT:  if (r_cnt == 2'd0) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= c_cpu;
            r_last  <= c_ldr;
            r_we    <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_cnt   <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                        r_we    <= (w_winner == c_ldr) ? d_we    : c_we;
                        r_addr  <= (w_winner == c_ldr) ? d_addr  : c_addr;
                        r_wdata <= (w_winner == c_ldr) ? d_wdata : c_wdata;
                    end
                end
                ST_ISSUE: r_cnt <= c_cnt_load;
                ST_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_last <= r_owner;
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from state and registered owner only.
    assign c_gnt     = (r_state != ST_IDLE) && (r_owner == c_cpu);
    assign d_gnt     = (r_state != ST_IDLE) && (r_owner == c_ldr);
    assign c_done    = (r_state == ST_DONE) && (r_owner == c_cpu);
    assign d_done    = (r_state == ST_DONE) && (r_owner == c_ldr);
    assign mem_we    = (r_state == ST_ISSUE) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter at MEM_LAT = 1 and 3.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        int         inst;
        bit         owner;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset     [2];
    logic       c_req     [2];
    logic       c_we      [2];
    logic [7:0] c_addr    [2];
    logic [7:0] c_wdata   [2];
    logic       d_req     [2];
    logic       d_we      [2];
    logic [7:0] d_addr    [2];
    logic [7:0] d_wdata   [2];
    logic       c_gnt     [2];
    logic       c_done    [2];
    logic       d_gnt     [2];
    logic       d_done    [2];
    logic [7:0] rdata     [2];
    logic [7:0] mem_addr  [2];
    logic [7:0] mem_wdata [2];
    logic       mem_we    [2];
    logic [7:0] mem_rdata [2];

    int         n_vec = 0;
    int         n_mis = 0;
    exp_t       sb [$];
    logic [7:0] ref_mem   [2][256];
    logic [7:0] exp_rdata [2];
    logic       prev_we   [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h3C);
    endfunction

    generate
        for (genvar i = 0; i < 2; i++) begin : g_dut
            localparam int L = (i == 0) ? LAT0 : LAT1;
            logic [7:0] mem_m    [256];
            bit         wr_valid [256];
            logic [7:0] pipe     [4];

            mem_arbiter #(.MEM_LAT(L)) u_dut (
                .clk       (clk),
                .reset     (reset[i]),
                .c_req     (c_req[i]),
                .c_we      (c_we[i]),
                .c_addr    (c_addr[i]),
                .c_wdata   (c_wdata[i]),
                .c_gnt     (c_gnt[i]),
                .c_done    (c_done[i]),
                .d_req     (d_req[i]),
                .d_we      (d_we[i]),
                .d_addr    (d_addr[i]),
                .d_wdata   (d_wdata[i]),
                .d_gnt     (d_gnt[i]),
                .d_done    (d_done[i]),
                .rdata     (rdata[i]),
                .mem_addr  (mem_addr[i]),
                .mem_wdata (mem_wdata[i]),
                .mem_we    (mem_we[i]),
                .mem_rdata (mem_rdata[i])
            );

            // Memory: address sampled each edge, data emerges L edges later.
            always @(posedge clk) begin
                if (mem_we[i]) begin
                    mem_m[mem_addr[i]]    <= mem_wdata[i];
                    wr_valid[mem_addr[i]] <= 1'b1;
                end
                pipe[0] <= wr_valid[mem_addr[i]] ? mem_m[mem_addr[i]] : init_val(mem_addr[i]);
                for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
            end
            assign mem_rdata[i] = pipe[L-1];
        end
    endgenerate

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic bit gnt_of(input int k, input bit who);
        return who ? d_gnt[k] : c_gnt[k];
    endfunction

    function automatic bit done_of(input int k, input bit who);
        return who ? d_done[k] : c_done[k];
    endfunction

    task automatic drive(input int k, input bit who, input bit req, input bit we,
                         input logic [7:0] addr, input logic [7:0] wd);
        if (who) begin
            d_req[k] = req; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
        end else begin
            c_req[k] = req; c_we[k] = we; c_addr[k] = addr; c_wdata[k] = wd;
        end
    endtask

    task automatic push_exp(input int k, input bit who, input bit we,
                            input logic [7:0] addr, input logic [7:0] wd);
        exp_t e;
        e.inst = k; e.owner = who; e.we = we; e.addr = addr; e.wdata = wd;
        if (we) begin
            ref_mem[k][addr] = wd;
            e.rdata = exp_rdata[k];
        end else begin
            e.rdata = ref_mem[k][addr];
            exp_rdata[k] = e.rdata;
        end
        sb.push_back(e);
    endtask

    // Single access; inputs are scrambled right after sampling to show they are ignored.
    task automatic access(input int k, input bit who, input bit we,
                          input logic [7:0] addr, input logic [7:0] wd);
        int n;
        bit got;
        push_exp(k, who, we, addr, wd);
        drive(k, who, 1'b1, we, addr, wd);
        @(negedge clk);
        check_eq("gnt_own",    int'(gnt_of(k, who)), 1);
        check_eq("gnt_other",  int'(gnt_of(k, !who)), 0);
        check_eq("issue_we",   int'(mem_we[k]), int'(we));
        check_eq("issue_addr", int'(mem_addr[k]), int'(addr));
        if (we) check_eq("issue_wdata", int'(mem_wdata[k]), int'(wd));
        drive(k, who, 1'b0, ~we, ~addr, ~wd);
        n = 1;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = done_of(k, who);
        end
        check_eq("latency", n, lat_of(k) + 2);
        @(negedge clk);
        check_eq("done_1cyc", int'(done_of(k, who)), 0);
        check_eq("gnt_idle",  int'(gnt_of(k, who)), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (reset[k]) begin
                check_eq("gnt_excl", int'(c_gnt[k] & d_gnt[k]), 0);
                if (mem_we[k]) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_we", int'(mem_we[k]), 0);
                    end else begin
                        check_eq("wr_is_write", int'(sb[0].we), 1);
                        check_eq("wr_addr",     int'(mem_addr[k]), int'(sb[0].addr));
                        check_eq("wr_data",     int'(mem_wdata[k]), int'(sb[0].wdata));
                        check_eq("we_1cyc",     int'(prev_we[k]), 0);
                    end
                end
                if (c_done[k] || d_done[k]) begin
                    check_eq("done_excl", int'(c_done[k] & d_done[k]), 0);
                    if (sb.size() == 0) begin
                        check_eq("spurious_done", int'(c_done[k] | d_done[k]), 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("sb_inst",  k, e.inst);
                        check_eq("sb_owner", int'(d_done[k]), int'(e.owner));
                        check_eq("sb_rdata", int'(rdata[k]), int'(e.rdata));
                    end
                end
            end
            prev_we[k] <= mem_we[k];
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int cg;
        int dg;
        bit pc;
        bit pd;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1;
            drive(k, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(k, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
            exp_rdata[k] = 8'h00;
            for (int a = 0; a < 256; a++) ref_mem[k][a] = init_val(8'(a));
        end
        #2;
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_c_gnt",  int'(c_gnt[k]), 0);
            check_eq("rst_d_gnt",  int'(d_gnt[k]), 0);
            check_eq("rst_c_done", int'(c_done[k]), 0);
            check_eq("rst_d_done", int'(d_done[k]), 0);
            check_eq("rst_mem_we", int'(mem_we[k]), 0);
            check_eq("rst_addr",   int'(mem_addr[k]), 0);
            check_eq("rst_wdata",  int'(mem_wdata[k]), 0);
            check_eq("rst_rdata",  int'(rdata[k]), 0);
        end
        repeat (2) @(negedge clk);
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        @(negedge clk);

        // MEM_LAT = 1: read, loader write, read-back
        access(0, 1'b0, 1'b0, 8'h10, 8'h00);
        access(0, 1'b1, 1'b1, 8'h20, 8'h3C);
        access(0, 1'b0, 1'b0, 8'h20, 8'h00);

        // Both requesters held from reset release: strict alternation, CPU first
        reset[0] = 1'b0;
        drive(0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h00);
        exp_rdata[0] = 8'h00;
        push_exp(0, 1'b0, 1'b0, 8'h10, 8'h00);
        push_exp(0, 1'b1, 1'b0, 8'h33, 8'h00);
        push_exp(0, 1'b0, 1'b0, 8'h10, 8'h00);
        push_exp(0, 1'b1, 1'b0, 8'h33, 8'h00);
        repeat (2) @(negedge clk);
        reset[0] = 1'b1;
        cg = 0; dg = 0; pc = 1'b0; pd = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (c_gnt[0] && !pc) begin
                cg++;
                if (cg == 2) c_req[0] = 1'b0;
            end
            if (d_gnt[0] && !pd) begin
                dg++;
                if (dg == 2) d_req[0] = 1'b0;
            end
            pc = c_gnt[0];
            pd = d_gnt[0];
            if (!c_req[0] && !d_req[0] && !c_gnt[0] && !d_gnt[0]) break;
        end
        check_eq("alt_cpu_grants", cg, 2);
        check_eq("alt_ldr_grants", dg, 2);
        check_eq("alt_sb_drained", sb.size(), 0);
        @(negedge clk);

        // MEM_LAT = 3
        access(1, 1'b0, 1'b0, 8'h10, 8'h00);
        access(1, 1'b1, 1'b1, 8'h44, 8'h99);
        access(1, 1'b1, 1'b0, 8'h44, 8'h00);

        // Reset asserted mid-WAIT aborts the access without a done pulse
        drive(1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        #2;
        reset[1] = 1'b0;
        #1;
        check_eq("abort_c_gnt",  int'(c_gnt[1]), 0);
        check_eq("abort_d_gnt",  int'(d_gnt[1]), 0);
        check_eq("abort_c_done", int'(c_done[1]), 0);
        check_eq("abort_d_done", int'(d_done[1]), 0);
        check_eq("abort_mem_we", int'(mem_we[1]), 0);
        check_eq("abort_addr",   int'(mem_addr[1]), 0);
        check_eq("abort_rdata",  int'(rdata[1]), 0);
        repeat (2) @(negedge clk);
        reset[1] = 1'b1;
        exp_rdata[1] = 8'h00;
        repeat (8) @(negedge clk);
        check_eq("abort_idle_gnt", int'(c_gnt[1]), 0);
        access(1, 1'b0, 1'b0, 8'h20, 8'h00);

        // Mixed traffic on both instances
        for (int r = 0; r < 10; r++) begin
            access($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        check_eq("final_sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
